uart_cmd_sequencer: RTL and testbench

Frames the byte stream from the UART receiver into length-delimited, checksummed command packets. It buffers each packet's payload and presents the complete command to the downstream controller over a valid/ready handshake. It sits between the UART receiver's byte handshake and the command consumer. It runs entirely on the 16x sampling clock and reports framing, length and timeout errors as single-cycle pulses.

---
 rtl/uart_cmd_sequencer_if.sv | 35 +++
 rtl/uart_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if
//   Bundles the receiver byte handshake, the command handshake and the error
//   pulses of the UART command sequencer.
//   master : the sequencer (takes rx_valid/rx_data/cmd_ready, drives the rest)
//   slave  : the surrounding system (receiver + command consumer)
//   Signals: rx_valid, rx_ready, rx_data[7:0], cmd_valid, cmd_ready,
//            cmd_opcode[7:0], cmd_len[3:0], cmd_payload[8*MAX_LEN-1:0],
//            err_checksum, err_length, err_timeout
interface uart_cmd_sequencer_if #(
   parameter int unsigned MAX_LEN = 8
);
   logic                 rx_valid;
   logic                 rx_ready;
   logic [7:0]           rx_data;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [7:0]           cmd_opcode;
   logic [3:0]           cmd_len;
   logic [8*MAX_LEN-1:0] cmd_payload;
   logic                 err_checksum;
   logic                 err_length;
   logic                 err_timeout;

   modport master (
      input  rx_valid, rx_data, cmd_ready,
      output rx_ready, cmd_valid, cmd_opcode, cmd_len, cmd_payload,
             err_checksum, err_length, err_timeout
   );

   modport slave (
      output rx_valid, rx_data, cmd_ready,
      input  rx_ready, cmd_valid, cmd_opcode, cmd_len, cmd_payload,
             err_checksum, err_length, err_timeout
   );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Frames received UART bytes (SYNC, OPCODE, LEN, LEN payload bytes, CHK)
//   into XOR-checksummed commands and offers each complete command on a
//   valid/ready handshake. Framing problems are reported as one-cycle pulses.
//   Ports:
//     uart_samplig_clk : 16x sampling clock, everything runs on it
//     reset            : synchronous, active-high
//     bus (master)     : rx byte handshake, command handshake, error pulses
module uart_cmd_sequencer #(
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int unsigned MAX_LEN       = 8,
   parameter logic [15:0] TIMEOUT_TICKS = 16'd4096
) (
   input logic                  uart_samplig_clk,
   input logic                  reset,
   uart_cmd_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      OPCODE  = 3'd1,
      LENGTH  = 3'd2,
      PAYLOAD = 3'd3,
      CHECK   = 3'd4,
      ISSUE   = 3'd5
   } state_t;

   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [15:0] TICK_LAST = TIMEOUT_TICKS - 16'd1;

   state_t               state;
   state_t               state_nxt;
   logic                 accept;
   logic                 in_frame;
   logic                 timeout_hit;
   logic                 len_bad;
   logic [15:0]          idle_cnt;
   logic [7:0]           acc;
   logic [7:0]           opcode_r;
   logic [3:0]           len_r;
   logic [3:0]           idx;
   logic [8*MAX_LEN-1:0] payload_r;
   logic                 err_checksum_r;
   logic                 err_length_r;
   logic                 err_timeout_r;

   assign accept   = bus.rx_valid && bus.rx_ready;
   assign in_frame = (state == OPCODE) || (state == LENGTH) ||
                     (state == PAYLOAD) || (state == CHECK);
   // An accepted byte wins over an expiring gap counter in the same cycle.
   assign timeout_hit = in_frame && !accept && (idle_cnt == TICK_LAST);
   assign len_bad     = (bus.rx_data > MAX_LEN_B);

   // State register
   always_ff @(posedge uart_samplig_clk) begin
      if (reset) state <= HUNT;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         HUNT: begin
            if (accept && (bus.rx_data == SYNC_BYTE)) state_nxt = OPCODE;
         end
         OPCODE: begin
            if (timeout_hit) state_nxt = HUNT;
            else if (accept) state_nxt = LENGTH;
         end
         LENGTH: begin
            if (timeout_hit) state_nxt = HUNT;
            else if (accept) begin
               if (len_bad)                   state_nxt = HUNT;
               else if (bus.rx_data == 8'd0)  state_nxt = CHECK;
               else                           state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (timeout_hit) state_nxt = HUNT;
            else if (accept && (idx == len_r - 4'd1)) state_nxt = CHECK;
         end
         CHECK: begin
            if (timeout_hit) state_nxt = HUNT;
            else if (accept) state_nxt = (bus.rx_data == acc) ? ISSUE : HUNT;
         end
         ISSUE: begin
            if (bus.cmd_ready) state_nxt = HUNT;
         end
         default: state_nxt = HUNT;
      endcase
   end

   // Handshake outputs, decoded from state only
   always_comb begin
      bus.rx_ready  = (state != ISSUE);
      bus.cmd_valid = (state == ISSUE);
   end

   // Inter-byte gap counter: only meaningful while a frame is being collected
   always_ff @(posedge uart_samplig_clk) begin
      if (reset || !in_frame || accept || timeout_hit) idle_cnt <= 16'd0;
      else                                             idle_cnt <= idle_cnt + 16'd1;
   end

   // Command fields, payload buffer and running XOR
   always_ff @(posedge uart_samplig_clk) begin
      if (reset) begin
         opcode_r  <= 8'd0;
         len_r     <= 4'd0;
         payload_r <= '0;
         acc       <= 8'd0;
         idx       <= 4'd0;
      end else if (accept) begin
         case (state)
            OPCODE: begin
               // Fresh frame: stale payload bytes must read as zero.
               opcode_r  <= bus.rx_data;
               payload_r <= '0;
               acc       <= bus.rx_data;
            end
            LENGTH: begin
               acc <= acc ^ bus.rx_data;
               if (!len_bad) begin
                  len_r <= bus.rx_data[3:0];
                  idx   <= 4'd0;
               end
            end
            PAYLOAD: begin
               for (int i = 0; i < int'(MAX_LEN); i++) begin
                  if (idx == 4'(i)) payload_r[8*i +: 8] <= bus.rx_data;
               end
               acc <= acc ^ bus.rx_data;
               idx <= idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Registered error pulses; the detecting conditions are mutually exclusive
   always_ff @(posedge uart_samplig_clk) begin
      if (reset) begin
         err_checksum_r <= 1'b0;
         err_length_r   <= 1'b0;
         err_timeout_r  <= 1'b0;
      end else begin
         err_checksum_r <= (state == CHECK)  && accept && (bus.rx_data != acc);
         err_length_r   <= (state == LENGTH) && accept && len_bad;
         err_timeout_r  <= timeout_hit;
      end
   end

   assign bus.cmd_opcode   = opcode_r;
   assign bus.cmd_len      = len_r;
   assign bus.cmd_payload  = payload_r;
   assign bus.err_checksum = err_checksum_r;
   assign bus.err_length   = err_length_r;
   assign bus.err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;
   localparam int          MAX_LEN = 8;
   localparam logic [7:0]  SYNC    = 8'hA5;
   localparam int          TO      = 32;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   bit   armed;
   bit   rand_rdy;

   uart_cmd_sequencer_if #(.MAX_LEN(MAX_LEN)) bus ();

   uart_cmd_sequencer #(
      .SYNC_BYTE    (SYNC),
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_TICKS(16'(TO))
   ) dut (
      .uart_samplig_clk(clk),
      .reset           (reset),
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level) ----------------
   bit         m_issue, m_insync, m_clean;
   logic [7:0] q[$];
   int         m_idle;
   logic [7:0] m_op;
   logic [3:0] m_len;
   logic [63:0] m_pay;
   bit         e_chk, e_len, e_to;
   int         n_hs, n_echk, n_elen, n_eto;
   logic [7:0] hs_op;
   logic [3:0] hs_len;
   logic [63:0] hs_pay;

   always @(negedge clk) begin
      logic [7:0] x;
      if (armed) begin
         check("rx_ready", bus.rx_ready, !m_issue);
         check("cmd_valid", bus.cmd_valid, m_issue);
         check("err_checksum", bus.err_checksum, e_chk);
         check("err_length", bus.err_length, e_len);
         check("err_timeout", bus.err_timeout, e_to);
         if (m_issue) begin
            check("cmd_opcode", bus.cmd_opcode, m_op);
            check("cmd_len", bus.cmd_len, m_len);
            check("cmd_payload", bus.cmd_payload, m_pay);
         end else if (m_clean) begin
            check("clr_opcode", bus.cmd_opcode, 0);
            check("clr_len", bus.cmd_len, 0);
            check("clr_payload", bus.cmd_payload, 0);
         end
         if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               n_hs++;
               hs_op = bus.cmd_opcode; hs_len = bus.cmd_len; hs_pay = bus.cmd_payload;
            end
            n_echk += int'(bus.err_checksum);
            n_elen += int'(bus.err_length);
            n_eto  += int'(bus.err_timeout);
         end
      end
      // advance the model with the inputs the next edge will see
      e_chk = 0; e_len = 0; e_to = 0;
      if (reset) begin
         m_issue = 0; m_insync = 0; m_clean = 1; q.delete(); m_idle = 0;
      end else if (m_issue) begin
         if (bus.cmd_ready) m_issue = 0;
      end else if (!m_insync) begin
         if (bus.rx_valid && bus.rx_data == SYNC) begin
            m_insync = 1; m_idle = 0; q.delete();
         end
      end else if (bus.rx_valid) begin
         q.push_back(bus.rx_data); m_idle = 0; m_clean = 0;
         if (q.size() == 2 && q[1] > MAX_LEN) begin
            e_len = 1; m_insync = 0;
         end else if (q.size() >= 2 && q.size() == 3 + int'(q[1])) begin
            x = 8'd0;
            for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
            if (x == q[q.size()-1]) begin
               m_issue = 1; m_op = q[0]; m_len = q[1][3:0]; m_pay = '0;
               for (int i = 0; i < int'(q[1]); i++) m_pay[8*i +: 8] = q[2+i];
            end else begin
               e_chk = 1;
            end
            m_insync = 0;
         end
      end else if (m_idle == TO - 1) begin
         e_to = 1; m_insync = 0;
      end else begin
         m_idle++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
      if (rand_rdy) bus.cmd_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit done;
      int n;
      repeat (gap) tick();
      bus.rx_valid = 1'b1; bus.rx_data = b;
      done = 0; n = 0;
      while (!done && n < 2000) begin
         @(negedge clk); done = bus.rx_ready;
         tick(); n++;
      end
      if (!done) check("rx_accept_bound", 0, 1);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send_byte(s[i], 0);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
   endtask

   int b_hs, b_chk, b_len, b_to;
   task automatic snap();
      b_hs = n_hs; b_chk = n_echk; b_len = n_elen; b_to = n_eto;
   endtask
   task automatic expect_counts(input string tag, input int hs, input int c, input int l, input int t);
      check({tag, "_hs"},  n_hs - b_hs, hs);
      check({tag, "_chk"}, n_echk - b_chk, c);
      check({tag, "_len"}, n_elen - b_len, l);
      check({tag, "_to"},  n_eto - b_to, t);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0; n_fail = 0; armed = 0; rand_rdy = 0;
      n_hs = 0; n_echk = 0; n_elen = 0; n_eto = 0;
      reset = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.cmd_ready = 1'b1;
      @(posedge clk); #1; armed = 1; tick(); reset = 1'b0;
      @(negedge clk);
      check("rst_rx_ready", bus.rx_ready, 1);
      check("rst_cmd_valid", bus.cmd_valid, 0);
      check("rst_payload", bus.cmd_payload, 0);
      tick();

      // good frame
      snap();
      send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      repeat (3) tick();
      expect_counts("good", 1, 0, 0, 0);
      check("good_op", hs_op, 8'h10);
      check("good_len", hs_len, 2);
      check("good_pay", hs_pay, 64'h2211);

      // zero length after junk
      snap();
      send_seq('{8'h00, 8'h55, 8'hA5, 8'h3C, 8'h00, 8'h3C});
      repeat (3) tick();
      expect_counts("zlen", 1, 0, 0, 0);
      check("zlen_op", hs_op, 8'h3C);
      check("zlen_len", hs_len, 0);
      check("zlen_pay", hs_pay, 0);

      // bad checksum then good frame
      snap();
      send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
      send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      repeat (3) tick();
      expect_counts("badchk", 1, 1, 0, 0);

      // length over limit, trailing byte dropped
      snap();
      send_seq('{8'hA5, 8'h10, 8'h09, 8'h33});
      repeat (3) tick();
      expect_counts("badlen", 0, 0, 1, 0);

      // timeout, then a byte landing exactly on the expiring cycle
      snap();
      send_seq('{8'hA5, 8'h10});
      repeat (40) tick();
      expect_counts("tmo", 0, 0, 0, 1);
      snap();
      send_seq('{8'hA5, 8'h10});
      send_byte(8'h02, TO - 1);
      send_seq('{8'h11, 8'h22, 8'h21});
      repeat (3) tick();
      expect_counts("tmo_edge", 1, 0, 0, 0);

      // backpressure
      snap();
      bus.cmd_ready = 1'b0;
      send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      repeat (50) tick();
      @(negedge clk);
      check("bp_rx_ready", bus.rx_ready, 0);
      check("bp_valid", bus.cmd_valid, 1);
      tick();
      bus.cmd_ready = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      check("bp_rx_ready_after", bus.rx_ready, 1);
      tick();
      expect_counts("bp", 1, 0, 0, 0);

      // reset mid-payload and reset while holding a command
      snap();
      send_seq('{8'hA5, 8'h10, 8'h04, 8'h11, 8'h22});
      do_reset();
      @(negedge clk);
      check("midrst_opcode", bus.cmd_opcode, 0);
      check("midrst_len", bus.cmd_len, 0);
      tick();
      bus.cmd_ready = 1'b0;
      send_seq('{8'hA5, 8'h77, 8'h01, 8'h5A, 8'h2C});
      repeat (3) tick();
      do_reset();
      @(negedge clk);
      check("issrst_valid", bus.cmd_valid, 0);
      tick();
      bus.cmd_ready = 1'b1;
      repeat (3) tick();
      expect_counts("rst", 0, 0, 0, 0);

      // randomized frames
      rand_rdy = 1;
      for (int f = 0; f < 300; f++) begin
         logic [7:0] fr[$];
         logic [7:0] x;
         int kind, len, g;
         kind = $urandom_range(0, 9);
         len  = $urandom_range(0, MAX_LEN);
         fr.delete();
         fr.push_back(SYNC);
         fr.push_back(8'($urandom));
         fr.push_back(8'(len));
         for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
         x = 8'd0;
         for (int i = 1; i < fr.size(); i++) x ^= fr[i];
         fr.push_back(x);
         if (kind == 6) fr[fr.size()-1] = x ^ 8'($urandom_range(1, 255));
         if (kind == 7) begin
            fr[2] = 8'($urandom_range(MAX_LEN + 1, 255));
            while (fr.size() > 3) void'(fr.pop_back());
         end
         if (kind == 8) begin
            fr.delete();
            repeat ($urandom_range(1, 3)) fr.push_back(8'($urandom));
         end
         if (kind == 9) begin
            while (fr.size() > 1 + $urandom_range(1, 3)) void'(fr.pop_back());
         end
         foreach (fr[i]) begin
            g = $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) g = $urandom_range(TO - 2, TO + 1);
            send_byte(fr[i], g);
         end
         if (kind == 9) repeat (TO + 4) tick();
      end
      rand_rdy = 0;
      bus.cmd_ready = 1'b1;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
